gate_sweep_sequencer: RTL and testbench

Upstream stimulus and capture stage for the two-input gate block. It drives x/y through the four input combinations (00, 01, 10, 11) and holds each for a programmable number of cycles. At the end of each window it samples the gate block's response vector and compares it against an expected truth table. It then reports per-vector pass/fail, giving the gate block a self-checking, clocked harness that can also be reused on silicon/FPGA.

---
 rtl/gate_sweep_sequencer_if.sv | 26 ++
 rtl/gate_sweep_sequencer.sv | 114 +++++++++++
 tb/tb_gate_sweep_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_sweep_sequencer_if.sv
// Bundle of stimulus, response and result signals shared between the gate
// sweep sequencer (slave) and whatever hosts it: the gate block, a bench, or a top-level.
interface gate_sweep_sequencer_if #(
  parameter int RESP_W = 10
);
  logic                  start;
  logic [RESP_W-1:0]     resp;
  logic [4*RESP_W-1:0]   exp_tbl;
  logic                  x;
  logic                  y;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [3:0]            err_mask;
  logic [4*RESP_W-1:0]   capture;

  modport master (
    output start, resp, exp_tbl,
    input  x, y, busy, done, pass, err_mask, capture
  );

  modport slave (
    input  start, resp, exp_tbl,
    output x, y, busy, done, pass, err_mask, capture
  );
endinterface

// File: rtl/gate_sweep_sequencer.sv
// Drives x/y through 00,01,10,11, holds each for HOLD_CYCLES, samples the gate
// response at the end of each window and flags mismatches against exp_tbl.
module gate_sweep_sequencer #(
  parameter int RESP_W      = 10,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  gate_sweep_sequencer_if.slave  bus
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t                state, state_next;
  logic [1:0]            vec, vec_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic [4*RESP_W-1:0]   capture_q, capture_next;
  logic [3:0]            err_q, err_next;
  logic                  pass_q, pass_next;
  logic                  x_q, y_q, busy_q, done_q;
  logic                  x_next, y_next, busy_next, done_next;

  // All outputs come straight from flops loaded with next-state decodes, so x/y never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vec       <= 2'd0;
      cnt       <= '0;
      capture_q <= '0;
      err_q     <= 4'd0;
      pass_q    <= 1'b0;
      x_q       <= 1'b0;
      y_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_next;
      vec       <= vec_next;
      cnt       <= cnt_next;
      capture_q <= capture_next;
      err_q     <= err_next;
      pass_q    <= pass_next;
      x_q       <= x_next;
      y_q       <= y_next;
      busy_q    <= busy_next;
      done_q    <= done_next;
    end
  end

  always_comb begin
    state_next   = state;
    vec_next     = vec;
    cnt_next     = cnt;
    capture_next = capture_q;
    err_next     = err_q;
    pass_next    = pass_q;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next   = DRIVE;
          vec_next     = 2'd0;
          cnt_next     = '0;
          capture_next = '0;
          err_next     = 4'd0;
          pass_next    = 1'b0;
        end
      end
      DRIVE: begin
        if (cnt == CNT_LAST) begin
          cnt_next = '0;
          // Constant slices per vector keep the sampling mux simple and width-clean.
          for (int v = 0; v < 4; v++) begin
            if (vec == 2'(v)) begin
              capture_next[v*RESP_W +: RESP_W] = bus.resp;
              err_next[v] = (bus.resp != bus.exp_tbl[v*RESP_W +: RESP_W]);
            end
          end
          if (vec == 2'd3) begin
            state_next = DONE;
            pass_next  = (err_next == 4'd0);
          end else begin
            vec_next = vec + 2'd1;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next == DRIVE);
    done_next = (state_next == DONE);
    x_next    = busy_next & vec_next[1];
    y_next    = busy_next & vec_next[0];
  end

  assign bus.x        = x_q;
  assign bus.y        = y_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.err_mask = err_q;
  assign bus.capture  = capture_q;

endmodule

// File: tb/tb_gate_sweep_sequencer.sv
// Bench for gate_sweep_sequencer: models the gate block as base^{x,y} and
// compares each sweep against a per-vector reference computed from the rules.
module tb_gate_sweep_sequencer;

  localparam int RW = 10;
  localparam int H2 = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [RW-1:0] base = 10'h2A5;
  int            checks = 0;
  int            failures = 0;

  gate_sweep_sequencer_if #(.RESP_W(RW)) bus2 ();
  gate_sweep_sequencer_if #(.RESP_W(RW)) bus1 ();

  assign bus2.resp = base ^ {8'h0, bus2.x, bus2.y};
  assign bus1.resp = base ^ {8'h0, bus1.x, bus1.y};

  gate_sweep_sequencer #(.RESP_W(RW), .HOLD_CYCLES(H2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  gate_sweep_sequencer #(.RESP_W(RW), .HOLD_CYCLES(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4*RW-1:0] ref_capture(input logic [RW-1:0] b);
    logic [4*RW-1:0] r;
    r = '0;
    for (int v = 0; v < 4; v++) r[v*RW +: RW] = b ^ RW'(v);
    return r;
  endfunction

  function automatic logic [3:0] ref_err(input logic [RW-1:0] b, input logic [4*RW-1:0] e);
    logic [3:0] m;
    m = 4'd0;
    for (int v = 0; v < 4; v++) m[v] = ((b ^ RW'(v)) != e[v*RW +: RW]);
    return m;
  endfunction

  function automatic logic [4*RW-1:0] make_exp(input logic [RW-1:0] b, input logic [3:0] faults);
    logic [4*RW-1:0] e;
    for (int v = 0; v < 4; v++)
      e[v*RW +: RW] = (b ^ RW'(v)) ^ (faults[v] ? RW'($urandom_range(1, 1023)) : RW'(0));
    return e;
  endfunction

  // One pulse-started sweep on the HOLD=2 instance; optional extra start at busy cycle again_at.
  task automatic run_sweep2(input string name, input logic [RW-1:0] b,
                            input logic [4*RW-1:0] e, input int again_at);
    logic [4:0]      exp_f;
    logic [3:0]      err_r;
    logic [4*RW-1:0] cap_r;
    int              vec;
    base         = b;
    bus2.exp_tbl = e;
    err_r        = ref_err(b, e);
    cap_r        = ref_capture(b);
    bus2.start   = 1'b1;
    tick();
    bus2.start   = 1'b0;
    for (int k = 1; k <= 4*H2; k++) begin
      vec   = (k - 1) / H2;
      exp_f = {1'b1, 1'b0, vec[1], vec[0], 1'b0};
      checks++;
      if ({bus2.busy, bus2.done, bus2.x, bus2.y, bus2.pass} !== exp_f) begin
        failures++;
        $display("[TB] FAIL %s drive k=%0d busy/done/x/y/pass got %b expected %b",
                 name, k, {bus2.busy, bus2.done, bus2.x, bus2.y, bus2.pass}, exp_f);
      end
      if (k == 1) begin
        checks++;
        if ({bus2.err_mask, bus2.capture} !== '0) begin
          failures++;
          $display("[TB] FAIL %s clear_on_start got err=%b cap=%h expected 0",
                   name, bus2.err_mask, bus2.capture);
        end
      end
      bus2.start = (k == again_at);
      tick();
      bus2.start = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      exp_f = {1'b0, (k == 0), 1'b0, 1'b0, (err_r == 4'd0)};
      checks++;
      if ({bus2.busy, bus2.done, bus2.x, bus2.y, bus2.pass} !== exp_f) begin
        failures++;
        $display("[TB] FAIL %s end k=%0d busy/done/x/y/pass got %b expected %b",
                 name, k, {bus2.busy, bus2.done, bus2.x, bus2.y, bus2.pass}, exp_f);
      end
      checks++;
      if (bus2.err_mask !== err_r || bus2.capture !== cap_r) begin
        failures++;
        $display("[TB] FAIL %s results k=%0d got err=%b cap=%h expected err=%b cap=%h",
                 name, k, bus2.err_mask, bus2.capture, err_r, cap_r);
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if ({bus2.x, bus2.y, bus2.busy, bus2.done, bus2.pass, bus2.err_mask, bus2.capture} !== '0 ||
          {bus1.x, bus1.y, bus1.busy, bus1.done, bus1.pass, bus1.err_mask, bus1.capture} !== '0) begin
        failures++;
        $display("[TB] FAIL reset_idle k=%0d got busy=%b done=%b pass=%b err=%b cap=%h expected all zero",
                 k, bus2.busy, bus2.done, bus2.pass, bus2.err_mask, bus2.capture);
      end
      tick();
    end
  endtask

  task automatic test_nominal();
    run_sweep2("nominal", 10'h2A5, {10'h2A6, 10'h2A7, 10'h2A4, 10'h2A5}, 0);
  endtask

  task automatic test_single_fault();
    run_sweep2("single_fault", 10'h2A5, {10'h2A6, 10'h000, 10'h2A4, 10'h2A5}, 0);
  endtask

  task automatic test_start_during_sweep();
    run_sweep2("start_during", 10'h2A5, {10'h2A6, 10'h2A7, 10'h2A4, 10'h2A5}, 3);
  endtask

  task automatic test_random();
    logic [RW-1:0] b;
    for (int i = 0; i < 8; i++) begin
      b = RW'($urandom_range(0, 1023));
      run_sweep2("random", b, make_exp(b, 4'($urandom_range(0, 15))), 0);
    end
  endtask

  task automatic test_reset_mid();
    base         = 10'h2A5;
    bus2.exp_tbl = {10'h2A6, 10'h2A7, 10'h2A4, 10'h2A5};
    bus2.start   = 1'b1;
    tick();
    bus2.start   = 1'b0;
    repeat (4) tick();
    checks++;
    if ({bus2.busy, bus2.x} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL reset_mid pre busy/x got %b expected 11", {bus2.busy, bus2.x});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus2.x, bus2.y, bus2.busy, bus2.done, bus2.pass, bus2.err_mask, bus2.capture} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_mid async got x=%b y=%b busy=%b done=%b err=%b cap=%h expected all zero",
               bus2.x, bus2.y, bus2.busy, bus2.done, bus2.err_mask, bus2.capture);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({bus2.busy, bus2.done, bus2.err_mask, bus2.capture} !== '0) begin
        failures++;
        $display("[TB] FAIL reset_mid held k=%0d got busy=%b done=%b err=%b expected zero",
                 k, bus2.busy, bus2.done, bus2.err_mask);
      end
    end
    rst_n = 1'b1;
    tick();
    run_sweep2("after_reset", 10'h2A5, {10'h2A6, 10'h2A7, 10'h2A4, 10'h2A5}, 0);
  endtask

  // Start held high on the HOLD=1 instance: period of 4 DRIVE + DONE + IDLE.
  task automatic test_back_to_back();
    logic [RW-1:0]   b;
    logic [4*RW-1:0] e;
    logic [3:0]      err_r;
    logic [4*RW-1:0] cap_r;
    logic [3:0]      exp_f;
    int              p;
    b            = RW'($urandom_range(0, 1023));
    e            = make_exp(b, 4'b0010);
    base         = b;
    bus1.exp_tbl = e;
    err_r        = ref_err(b, e);
    cap_r        = ref_capture(b);
    bus1.start   = 1'b1;
    tick();
    for (int k = 1; k <= 18; k++) begin
      p     = (k - 1) % 6;
      exp_f = (p < 4) ? {1'b1, 1'b0, p[1], p[0]} : {1'b0, (p == 4), 1'b0, 1'b0};
      checks++;
      if ({bus1.busy, bus1.done, bus1.x, bus1.y} !== exp_f) begin
        failures++;
        $display("[TB] FAIL back_to_back k=%0d busy/done/x/y got %b expected %b",
                 k, {bus1.busy, bus1.done, bus1.x, bus1.y}, exp_f);
      end
      if (p == 0) begin
        checks++;
        if ({bus1.pass, bus1.err_mask, bus1.capture} !== '0) begin
          failures++;
          $display("[TB] FAIL back_to_back_clear k=%0d got pass=%b err=%b cap=%h expected 0",
                   k, bus1.pass, bus1.err_mask, bus1.capture);
        end
      end
      if (p >= 4) begin
        checks++;
        if (bus1.pass !== 1'b0 || bus1.err_mask !== err_r || bus1.capture !== cap_r) begin
          failures++;
          $display("[TB] FAIL back_to_back_result k=%0d got pass=%b err=%b cap=%h expected pass=0 err=%b cap=%h",
                   k, bus1.pass, bus1.err_mask, bus1.capture, err_r, cap_r);
        end
      end
      if (k == 18) bus1.start = 1'b0;
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({bus1.busy, bus1.done, bus1.x, bus1.y} !== 4'b0000) begin
        failures++;
        $display("[TB] FAIL back_to_back_stop k=%0d busy/done/x/y got %b expected 0000",
                 k, {bus1.busy, bus1.done, bus1.x, bus1.y});
      end
      tick();
    end
  endtask

  initial begin
    bus2.start   = 1'b0;
    bus1.start   = 1'b0;
    bus2.exp_tbl = '0;
    bus1.exp_tbl = '0;
    test_reset();
    test_nominal();
    test_single_fault();
    test_start_during_sweep();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
